// File: rtl/instr_pkg.sv
// -----------------------------------------------------------------------------
// instr_pkg
// Shared definitions for the instruction loader: ARM instruction class codes,
// the loader FSM state type, the decoded-field bundle and the word packing /
// encoding-check helpers used by instr_pack.
// No ports (package).
// -----------------------------------------------------------------------------
package instr_pkg;

  // Instruction class codes (word bits [27:26])
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // "Always" condition code
  localparam logic [3:0] COND_AL = 4'hE;

  // Loader session states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } ld_state_e;

  // Decoded instruction fields as delivered on one input beat
  typedef struct packed {
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [23:0] imm;
  } instr_fields_t;

  // Pack decoded fields into a 32-bit ARM word. The reserved class is
  // emitted with a data-processing class field so the word stays decodable.
  function automatic logic [31:0] pack_word(input instr_fields_t f);
    logic [31:0] w;
    case (f.op)
      OP_BR:   w = {f.cond, OP_BR, f.funct[5:4], f.imm};
      OP_RSV:  w = {f.cond, OP_DP, f.funct, f.rn, f.rd, f.imm[11:0]};
      default: w = {f.cond, f.op, f.funct, f.rn, f.rd, f.imm[11:0]};
    endcase
    return w;
  endfunction

  // Encodings the core cannot execute: reserved class, or a branch whose
  // funct[5] (the fixed '1' of the branch opcode) is clear.
  function automatic logic encoding_bad(input instr_fields_t f);
    logic bad;
    if (f.op == OP_RSV) begin
      bad = 1'b1;
    end else if ((f.op == OP_BR) && (f.funct[5] == 1'b0)) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Combinational field-to-word packer with optional encoding checker.
// Optional feature macro: LDR_CHECK_EN (when defined, 'bad' flags encodings
// the core cannot execute; otherwise 'bad' is constant 0).
// Ports:
//   fields  in   decoded instruction fields (instr_fields_t)
//   word    out  packed 32-bit ARM instruction word
//   bad     out  encoding rejected by the checker
// -----------------------------------------------------------------------------
module instr_pack
  import instr_pkg::*;
(
  input  instr_fields_t fields,
  output logic [31:0]   word,
  output logic          bad
);

  // Pack the fields and evaluate the encoding check
  always_comb begin
    word = pack_word(fields);
`ifdef LDR_CHECK_EN
    bad  = encoding_bad(fields);
`else
    bad  = 1'b0;
`endif
  end

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Accepts decoded instruction fields over a valid/ready stream, packs each
// beat into a 32-bit ARM word and writes the words sequentially into
// instruction memory starting at BASE_ADDR. Holds the core in reset while a
// session is active.
// Optional feature macro: LDR_CHECK_EN (reject unexecutable encodings and
// report them on the sticky 'err' output; without it 'err' stays 0).
// Parameters:
//   DEPTH      instruction memory size in words (power of two)
//   BASE_ADDR  byte address of the first word written
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 pulse: begin a session (ignored while loading)
//   in_valid/in_ready     beat handshake, in_last marks the final beat
//   in_cond..in_imm       decoded instruction fields
//   im_we/im_addr/im_wdata  registered instruction memory write port
//   cpu_hold              core reset request while loading
//   done                  sticky session-complete flag
//   count                 words written in the current session
//   err                   sticky encoding error (LDR_CHECK_EN only)
// -----------------------------------------------------------------------------
module instr_loader
  import instr_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [3:0]                 in_cond,
  input  logic [1:0]                 in_op,
  input  logic [5:0]                 in_funct,
  input  logic [3:0]                 in_rn,
  input  logic [3:0]                 in_rd,
  input  logic [23:0]                in_imm,
  output logic                       im_we,
  output logic [31:0]                im_addr,
  output logic [31:0]                im_wdata,
  output logic                       cpu_hold,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  ld_state_e     state_q, state_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          im_we_q, im_we_d;
  logic [31:0]   im_addr_q, im_addr_d;
  logic [31:0]   im_wdata_q, im_wdata_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  instr_fields_t fields_s;
  logic [31:0]   word_s;
  logic          bad_s;
  logic          accept_s;
  logic [CW-1:0] count_inc_s;

  // Gather the beat fields for the packer
  always_comb begin
    fields_s.cond  = in_cond;
    fields_s.op    = in_op;
    fields_s.funct = in_funct;
    fields_s.rn    = in_rn;
    fields_s.rd    = in_rd;
    fields_s.imm   = in_imm;
  end

  instr_pack u_pack (
    .fields (fields_s),
    .word   (word_s),
    .bad    (bad_s)
  );

  // Next-state and next-output computation for the load session
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    count_d     = count_q;
    err_d       = err_q;
    im_we_d     = 1'b0;
    im_addr_d   = im_addr_q;
    im_wdata_d  = im_wdata_q;
    // in_ready_q is only ever high in LOAD, so this is the handshake itself
    accept_s    = in_ready_q && in_valid;
    count_inc_s = count_q + CNT_ONE;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = LOAD;
          wr_addr_d = BASE_ADDR;
          count_d   = {CW{1'b0}};
          err_d     = 1'b0;
        end else begin
          state_d   = state_q;
        end
      end
      LOAD: begin
        if (accept_s && !bad_s) begin
          im_we_d    = 1'b1;
          im_addr_d  = wr_addr_q;
          im_wdata_d = word_s;
          wr_addr_d  = wr_addr_q + 32'd4;
          count_d    = count_inc_s;
          // Stop on the last beat or once memory is full: never wrap
          if (in_last || (count_inc_s == FULL_CNT)) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end else if (accept_s) begin
          // Rejected beat: handshake completes, nothing is written
          err_d = 1'b1;
          if (in_last) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifndef LDR_CHECK_EN
    err_d = 1'b0;
`endif

    in_ready_d = (state_d == LOAD);
    // Keep the core held through the cycle that carries the final strobe
    cpu_hold_d = (state_d == LOAD) || accept_s;
    done_d     = (state_d == DONE);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_addr_q  <= BASE_ADDR;
      count_q    <= {CW{1'b0}};
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= BASE_ADDR;
      im_wdata_q <= 32'h0000_0000;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign count    = count_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
// Directed bench for instr_loader (DEPTH=4). A behavioural session model
// predicts every output each cycle; literal checks on the captured write log
// pin the model against hand-computed ARM words.
// -----------------------------------------------------------------------------
module tb_instr_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef LDR_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, in_last;
  logic [3:0]  in_cond, in_rn, in_rd;
  logic [1:0]  in_op;
  logic [5:0]  in_funct;
  logic [23:0] in_imm;
  logic        im_we, cpu_hold, done, err;
  logic [31:0] im_addr, im_wdata;
  logic [2:0]  count;

  instr_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_cond(in_cond), .in_op(in_op),
    .in_funct(in_funct), .in_rn(in_rn), .in_rd(in_rd), .in_imm(in_imm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int hold_cycles = 0;
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] la(input int i);
    if (i < log_a.size()) return log_a[i];
    else return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ld(input int i);
    if (i < log_d.size()) return log_d[i];
    else return 32'hFFFF_FFFF;
  endfunction

  // Reference word built arithmetically from the field positions
  function automatic logic [31:0] ref_word(input logic [3:0] c, input logic [1:0] op,
                                           input logic [5:0] f, input logic [3:0] rn,
                                           input logic [3:0] rd, input logic [23:0] imm);
    logic [31:0] w;
    logic [1:0]  cls;
    logic [1:0]  f_hi;
    w = 32'(c) * 32'h1000_0000;
    if (op == 2'd2) begin
      f_hi = f[5:4];
      w = w + 32'h0800_0000 + 32'(f_hi) * 32'h0100_0000 + 32'(imm);
    end else begin
      cls = (op == 2'd3) ? 2'd0 : op;
      w = w + 32'(cls) * 32'h0400_0000 + 32'(f) * 32'h0010_0000
            + 32'(rn) * 32'h0001_0000 + 32'(rd) * 32'h0000_1000 + 32'(imm & 24'hFFF);
    end
    return w;
  endfunction

  // ---------------- behavioural model ----------------
  int          m_sess = 0;      // 0 idle, 1 loading, 2 finished
  int          m_count = 0;
  bit          m_err = 1'b0, m_we = 1'b0, m_hold = 1'b0, m_rst = 1'b0, m_armed = 1'b0;
  logic [31:0] m_addr = BASE, m_wdata = 32'h0;

  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      m_sess = 0; m_count = 0; m_err = 1'b0; m_we = 1'b0; m_hold = 1'b0;
      m_addr = BASE; m_wdata = 32'h0; m_rst = 1'b1; m_armed = 1'b1;
    end else begin
      m_rst = 1'b0;
      m_we  = 1'b0;
      acc   = (m_sess == 1) && in_valid;
      if (acc) begin
        if (CHECK && (in_op == 2'd3 || (in_op == 2'd2 && !in_funct[5]))) begin
          m_err = 1'b1;
        end else begin
          m_we    = 1'b1;
          m_addr  = BASE + 32'(4 * m_count);
          m_wdata = ref_word(in_cond, in_op, in_funct, in_rn, in_rd, in_imm);
          m_count++;
        end
        if (in_last || m_count == DEPTH) m_sess = 2;
      end else if (start && m_sess != 1) begin
        m_sess = 1; m_count = 0; m_err = 1'b0;
      end
      m_hold = (m_sess == 1) || acc;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_armed) begin
      chk("in_ready", 32'(in_ready), 32'(m_sess == 1));
      chk("cpu_hold", 32'(cpu_hold), 32'(m_hold));
      chk("done",     32'(done),     32'(m_sess == 2));
      chk("count",    32'(count),    32'(m_count));
      chk("err",      32'(err),      32'(m_err));
      chk("im_we",    32'(im_we),    32'(m_we));
      if (m_we || m_rst) begin
        chk("im_addr",  im_addr,  m_addr);
        chk("im_wdata", im_wdata, m_wdata);
      end
      if (im_we) begin
        log_a.push_back(im_addr);
        log_d.push_back(im_wdata);
      end
      if (cpu_hold) hold_cycles++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_imm = 24'(($urandom_range(0, 255)));
  endtask

  task automatic beat(input logic last, input logic [1:0] op, input logic [5:0] f,
                      input logic [3:0] rn, input logic [3:0] rd, input logic [23:0] imm);
    in_valid = 1'b1; in_last = last; in_cond = instr_pkg::COND_AL;
    in_op = op; in_funct = f; in_rn = rn; in_rd = rd; in_imm = imm;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_cond = 4'h0; in_op = 2'd0; in_funct = 6'd0; in_rn = 4'd0; in_rd = 4'd0; in_imm = 24'd0;
    @(negedge clk); @(negedge clk);
    // reset values
    chk("rst_addr",  im_addr, BASE);
    chk("rst_wdata", im_wdata, 32'h0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    tick();

    // T1: single data-processing word
    log_a.delete(); log_d.delete(); hold_cycles = 0;
    tick(); start = 1'b1;
    tick(); beat(1'b1, 2'b00, 6'b101000, 4'd2, 4'd1, 24'h000005);
    repeat (3) tick();
    chk("t1_nwr",   32'(log_a.size()), 32'd1);
    chk("t1_addr",  la(0), 32'h0000_0000);
    chk("t1_word",  ld(0), 32'hE282_1005);
    chk("t1_done",  32'(done), 32'd1);
    chk("t1_hold",  32'(hold_cycles), 32'd2);
    chk("t1_count", 32'(count), 32'd1);

    // T2: LDR then branch
    log_a.delete(); log_d.delete();
    tick(); start = 1'b1;
    tick(); beat(1'b0, 2'b01, 6'b011001, 4'd4, 4'd3, 24'h000008);
    tick(); beat(1'b1, 2'b10, 6'b101111, 4'd7, 4'd7, 24'hFFFFFE);
    repeat (3) tick();
    chk("t2_a0", la(0), 32'h0000_0000);
    chk("t2_d0", ld(0), 32'hE594_3008);
    chk("t2_a1", la(1), 32'h0000_0004);
    chk("t2_d1", ld(1), 32'hEAFF_FFFE);
    chk("t2_count", 32'(count), 32'd2);

    // T3: fill memory, six beats without last
    log_a.delete(); log_d.delete();
    tick(); start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); beat(1'b0, 2'b00, 6'b001000, 4'd0, 4'(i), 24'(i));
    end
    repeat (2) tick();
    chk("t3_nwr",   32'(log_a.size()), 32'd4);
    chk("t3_a3",    la(3), 32'h0000_000C);
    chk("t3_d3",    ld(3), 32'hE080_3003);
    chk("t3_ready", 32'(in_ready), 32'd0);
    chk("t3_done",  32'(done), 32'd1);
    chk("t3_count", 32'(count), 32'd4);

    // T4: valid with gaps, plus a start pulse mid-session
    log_a.delete(); log_d.delete();
    tick(); start = 1'b1;
    tick(); beat(1'b0, 2'b01, 6'b011001, 4'd1, 4'd2, 24'h000004);
    tick(); in_op = 2'b10;
    tick(); beat(1'b0, 2'b10, 6'b110000, 4'd0, 4'd0, 24'h000010);
    tick();
    tick(); start = 1'b1;
    tick(); beat(1'b1, 2'b00, 6'b000100, 4'd3, 4'd4, 24'h0000FF);
    repeat (3) tick();
    chk("t4_nwr", 32'(log_a.size()), 32'd3);
    chk("t4_a1",  la(1), 32'h0000_0004);
    chk("t4_a2",  la(2), 32'h0000_0008);
    chk("t4_d0",  ld(0), 32'hE591_2004);
    chk("t4_d1",  ld(1), 32'hEB00_0010);
    chk("t4_d2",  ld(2), 32'hE043_40FF);
    chk("t4_count", 32'(count), 32'd3);

    // T5: reset after two of five beats (start in the same cycle as reset)
    log_a.delete(); log_d.delete();
    tick(); start = 1'b1;
    tick(); beat(1'b0, 2'b00, 6'b001000, 4'd0, 4'd1, 24'h000001);
    tick(); beat(1'b0, 2'b00, 6'b001000, 4'd0, 4'd2, 24'h000002);
    tick(); beat(1'b0, 2'b00, 6'b001000, 4'd0, 4'd3, 24'h000003); reset = 1'b1; start = 1'b1;
    tick(); beat(1'b0, 2'b00, 6'b001000, 4'd0, 4'd4, 24'h000004);
    tick(); beat(1'b1, 2'b00, 6'b001000, 4'd0, 4'd5, 24'h000005);
    tick();
    chk("t5_nwr",   32'(log_a.size()), 32'd2);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_hold",  32'(cpu_hold), 32'd0);
    chk("t5_done",  32'(done), 32'd0);
    tick(); start = 1'b1;
    tick(); beat(1'b1, 2'b00, 6'b001000, 4'd0, 4'd6, 24'h000006);
    repeat (2) tick();
    chk("t5_a2", la(2), 32'h0000_0000);
    chk("t5_d2", ld(2), 32'hE080_6006);

    // T6: reserved class in the middle of a session
    log_a.delete(); log_d.delete();
    tick(); start = 1'b1;
    tick(); beat(1'b0, 2'b00, 6'b001000, 4'd0, 4'd0, 24'h0000FF);
    tick(); beat(1'b0, 2'b11, 6'b000100, 4'd1, 4'd2, 24'h000003);
    tick(); beat(1'b1, 2'b00, 6'b011010, 4'd0, 4'd5, 24'h000001);
    repeat (3) tick();
    chk("t6_d0", ld(0), 32'hE080_00FF);
    if (CHECK) begin
      chk("t6_nwr",   32'(log_a.size()), 32'd2);
      chk("t6_a1",    la(1), 32'h0000_0004);
      chk("t6_d1",    ld(1), 32'hE1A0_5001);
      chk("t6_err",   32'(err), 32'd1);
      chk("t6_count", 32'(count), 32'd2);
    end else begin
      chk("t6_nwr",   32'(log_a.size()), 32'd3);
      chk("t6_d1",    ld(1), 32'hE041_2003);
      chk("t6_d2",    ld(2), 32'hE1A0_5001);
      chk("t6_err",   32'(err), 32'd0);
      chk("t6_count", 32'(count), 32'd3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Writer side of the instruction word consumed by the single-cycle ARM controller and datapath. It accepts decoded instruction fields over a valid/ready stream and packs them into 32-bit ARM words (data-processing, memory and branch classes). It writes the words sequentially into instruction memory and holds the processor in reset while loading. Lets the bench or a UART front-end program the core without rebuilding memory images.

## Interface
- DEPTH, 64: instruction memory size in words; must be a power of two.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; begins a load session at BASE_ADDR.
- in_valid  in  1  field beat valid.
- in_ready  out  1  beat accepted on the edge where in_valid && in_ready.
- in_last  in  1  marks the final beat of the session.
- in_cond  in  4  condition field, word bits [31:28].
- in_op  in  2  class: 00 data-processing, 01 memory, 10 branch.
- in_funct  in  6  word bits [25:20]: {I,cmd,S} or {~I,P,U,B,W,L}; branch uses [5:4] only.
- in_rn, in_rd  in  4 each  word bits [19:16], [15:12]; ignored for branch.
- in_imm  in  24  Src2 in [11:0] for classes 00/01; imm24 for branch.
- im_we  out  1  instruction memory write strobe.
- im_addr  out  32  byte address, word aligned.
- im_wdata  out  32  packed instruction word.
- cpu_hold  out  1  high while a session is active; drives the core reset.
- done  out  1  sticky; set when a session completes, cleared by start.
- count  out  $clog2(DEPTH)+1  words written in the current session.
- err  out  1  sticky encoding error, only with LDR_CHECK_EN; tied 0 otherwise.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE: in_ready=0, cpu_hold=0. start moves the FSM to LOAD, loads the address to BASE_ADDR and clears count, done and err.
- LOAD: in_ready=1 unless count==DEPTH. cpu_hold=1.
- Packing rules:
  - Classes 00/01: {cond, op, funct, rn, rd, imm[11:0]}.
  - Class 10: {cond, 2'b10, funct[5:4], imm[23:0]}.
  - Class 11 without the check: packed as class 00.
- Each accepted beat writes one word, then increments the address by 4 and increments count.
- Accepted beat with in_last=1 moves the FSM to DONE after the write.
- Full condition: count reaches DEPTH. in_ready drops and the FSM goes to DONE; no wrap-around and no overwrite.
- DONE: done=1, cpu_hold=0, in_ready=0. start re-enters LOAD.
- start while in LOAD is ignored. start in the same cycle as reset: reset wins.
- Reset mid-session: return to IDLE, drop im_we the next cycle, leave memory contents untouched.

## Timing
- Reset values: FSM=IDLE, in_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, cpu_hold=0, done=0, count=0, err=0.
- im_we, im_addr and im_wdata are registered, valid the cycle after acceptance; latency 1.
- Throughput: one word per cycle under back-to-back valid.
- cpu_hold rises the cycle after start. It falls the cycle after the last write strobe, so the core never fetches a half-written image.

## Configuration
- LDR_CHECK_EN defined:
  - Reject beats with in_op==2'b11, or branch beats with in_funct[5]==0.
  - A rejected beat is accepted (handshake completes) but is not written.
  - A rejected beat leaves address and count unchanged and sets err.
  - in_last on a rejected beat still ends the session.
- LDR_CHECK_EN undefined: no checking, err tied 0, class 11 packed as class 00.

## Structure
- Shared package instr_pkg: op class constants (OP_DP, OP_MEM, OP_BR), FSM state enum, cond value COND_AL=4'hE.
- One sub-module, instr_pack: combinational field-to-word packer (and checker when enabled). Reusable by the bench's reference model.

## Test plan
- start, then beat cond=E op=00 funct=101000 rn=2 rd=1 imm=005 with in_last -> one strobe at addr 0 with 32'hE2821005; done=1; cpu_hold high for 2 cycles.
- Beats LDR (op=01 funct=011001 rn=4 rd=3 imm=008), then B (op=10 funct=10xxxx imm=FFFFFE, last) -> E5943008 at addr 0, EAFFFFFE at addr 4; count=2.
- DEPTH=4, 6 beats with no last -> 4 writes at 0, 4, 8, C. in_ready low after the 4th write; DONE; no 5th strobe.
- in_valid toggling with gaps -> writes only on handshake cycles; addresses stay contiguous.
- reset asserted after 2 of 5 beats -> IDLE next cycle, outputs at reset values. A new start resumes writing at BASE_ADDR.
- LDR_CHECK_EN defined, beats op=00, op=11, op=00 -> two writes at addr 0 and 4; err=1; count=2.
